registro_desplazamiento_taps: RTL and testbench

- Parametrised successor to the single-sample flag-loaded filter register.
- Holds a DEPTH-deep history of signed samples for the FIR/IIR tap datapath.
- Each incoming 2N-style wide product is rescaled to W bits by arithmetic shift, then narrowed by truncation or saturation, and shifted in on a load flag.
- Exposes all taps, a fill count, a primed flag and a sticky overflow flag to the MAC stage.

---
 rtl/filtro_pkg.sv | 20 ++
 rtl/escalador_saturador.sv | 33 +++
 rtl/registro_desplazamiento_taps.sv | 60 ++++++
 tb/tb_registro_desplazamiento_taps.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/filtro_pkg.sv
// Shared types, constants and helpers for the filter tap datapath.
// Consumed by registro_desplazamiento_taps and escalador_saturador.
package filtro_pkg;

    // Index type used to walk the tap history.
    typedef int unsigned tap_idx_t;

    // Saturation bounds at the default stored sample width.
    localparam int     W_DEF = 25;
    localparam longint W_MAX = (longint'(1) << (W_DEF - 1)) - 1;
    localparam longint W_MIN = -(longint'(1) << (W_DEF - 1));

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/escalador_saturador.sv
// Rescales a wide signed product by FRAC bits and narrows it to W bits.
// REGISTRO_TAPS_SAT_EN selects clamping; otherwise the value wraps.
module escalador_saturador
    import filtro_pkg::*;
#(
    parameter int W    = 25,
    parameter int IN_W = 50,
    parameter int FRAC = 20
) (
    input  logic signed [IN_W-1:0] in,
    output logic signed [W-1:0]    out,
    output logic                   fuera_rango
);

    logic signed [IN_W-1:0] s;
    logic        [IN_W-W:0] sup;

    assign s   = in >>> FRAC;
    // s fits in W bits only when every bit from the W-1 sign position up agrees.
    assign sup = s[IN_W-1:W-1];
    assign fuera_rango = !((&sup) || !(|sup));

`ifdef REGISTRO_TAPS_SAT_EN
    always_comb begin
        out = s[W-1:0];
        if (fuera_rango)
            out = s[IN_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`else
    assign out = s[W-1:0];
`endif

endmodule

// File: rtl/registro_desplazamiento_taps.sv
// DEPTH-deep signed sample history for the FIR/IIR tap datapath, updated on the falling edge.
// Narrowing mode follows the REGISTRO_TAPS_SAT_EN macro (see escalador_saturador).
module registro_desplazamiento_taps
    import filtro_pkg::*;
#(
    parameter int W     = 25,
    parameter int IN_W  = 50,
    parameter int FRAC  = 20,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          bandera,
    input  logic                          limpiar,
    input  logic signed [IN_W-1:0]        In,
    output logic        [DEPTH*W-1:0]     taps,
    output logic signed [W-1:0]           fk,
    output logic signed [W-1:0]           fk_ant,
    output logic [clog2(DEPTH+1)-1:0]     cuenta,
    output logic                          lleno,
    output logic                          desborde
);

    localparam int CW = clog2(DEPTH + 1);
    localparam logic [CW-1:0] LLENO_CNT = CW'(DEPTH);

    logic [DEPTH-1:0][W-1:0] hist;
    logic signed [W-1:0]     nuevo;
    logic                    fuera;
    logic [CW-1:0]           cuenta_sig;

    escalador_saturador #(.W(W), .IN_W(IN_W), .FRAC(FRAC)) u_esc (
        .in          (In),
        .out         (nuevo),
        .fuera_rango (fuera)
    );

    assign cuenta_sig = (cuenta == LLENO_CNT) ? cuenta : cuenta + 1'b1;

    always_ff @(negedge clk) begin
        if (reset || limpiar) begin
            hist     <= '0;
            cuenta   <= '0;
            lleno    <= 1'b0;
            desborde <= 1'b0;
        end else if (bandera) begin
            hist[0] <= nuevo;
            for (tap_idx_t k = 1; k < DEPTH; k++)
                hist[k] <= hist[k-1];
            cuenta   <= cuenta_sig;
            lleno    <= (cuenta_sig == LLENO_CNT);
            desborde <= desborde | fuera;
        end
    end

    assign taps   = hist;
    assign fk     = hist[0];
    assign fk_ant = hist[DEPTH-1];

endmodule

// File: tb/tb_registro_desplazamiento_taps.sv
// Directed scoreboard bench for registro_desplazamiento_taps (W=8, IN_W=16, FRAC=4, DEPTH=4).
// Expectations follow REGISTRO_TAPS_SAT_EN when it is defined for the build.
module tb_registro_desplazamiento_taps;

    localparam int W = 8, IN_W = 16, FRAC = 4, DEPTH = 4;

    logic                     clk = 1'b0;
    logic                     reset, bandera, limpiar;
    logic signed [IN_W-1:0]   In;
    logic [DEPTH*W-1:0]       taps;
    logic signed [W-1:0]      fk, fk_ant;
    logic [2:0]               cuenta;
    logic                     lleno, desborde;

    int checks = 0;
    int fails  = 0;

    int m_tap [DEPTH];
    int m_cnt, m_desb;
    int sb_q [$];

    registro_desplazamiento_taps #(.W(W), .IN_W(IN_W), .FRAC(FRAC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bandera(bandera), .limpiar(limpiar), .In(In),
        .taps(taps), .fk(fk), .fk_ant(fk_ant), .cuenta(cuenta), .lleno(lleno),
        .desborde(desborde)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Integer reference of the shift-then-narrow step.
    task automatic model_narrow(input logic [15:0] v, output int q, output int ovf);
        int x, s, w;
        x = int'($signed(v));
        s = (x >= 0) ? x / 16 : -((-x + 15) / 16);
        ovf = (s > 127 || s < -128) ? 1 : 0;
`ifdef REGISTRO_TAPS_SAT_EN
        q = (s > 127) ? 127 : (s < -128) ? -128 : s;
`else
        w = s & 255;
        q = (w > 127) ? w - 256 : w;
`endif
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".cuenta"}, int'(cuenta), m_cnt);
        chk({tag, ".lleno"}, int'(lleno), (m_cnt == DEPTH) ? 1 : 0);
        chk({tag, ".desborde"}, int'(desborde), m_desb);
        for (int k = 0; k < DEPTH; k++)
            chk($sformatf("%s.tap%0d", tag, k), int'($signed(taps[k*W +: W])), m_tap[k]);
        chk({tag, ".fk_ant"}, int'(fk_ant), m_tap[DEPTH-1]);
    endtask

    task automatic step(input string tag, input logic r, input logic l, input logic b,
                        input logic [15:0] v);
        int q, ovf;
        bit loaded;
        reset = r; limpiar = l; bandera = b; In = v;
        loaded = 1'b0;
        if (r || l) begin
            for (int k = 0; k < DEPTH; k++) m_tap[k] = 0;
            m_cnt = 0; m_desb = 0;
        end else if (b) begin
            model_narrow(v, q, ovf);
            for (int k = DEPTH-1; k > 0; k--) m_tap[k] = m_tap[k-1];
            m_tap[0] = q;
            if (m_cnt < DEPTH) m_cnt++;
            if (ovf != 0) m_desb = 1;
            sb_q.push_back(q);
            loaded = 1'b1;
        end
        @(negedge clk);
        #2;
        if (loaded) chk({tag, ".fk"}, int'(fk), sb_q.pop_front());
        else        chk({tag, ".fk"}, int'(fk), m_tap[0]);
        check_state(tag);
    endtask

    initial begin
        reset = 1'b1; limpiar = 1'b0; bandera = 1'b0; In = '0;
        for (int k = 0; k < DEPTH; k++) m_tap[k] = 0;
        m_cnt = 0; m_desb = 0;

        step("rst", 1, 0, 0, 16'h0000);
        step("rst_rel", 0, 0, 0, 16'h1234);

        // Basic fill: newest..oldest = 1, -2, 4, 18
        step("ld1", 0, 0, 1, 16'h0120);
        step("ld2", 0, 0, 1, 16'h0040);
        step("ld3", 0, 0, 1, 16'hFFE0);
        step("ld4", 0, 0, 1, 16'h0010);

        // Out-of-range positive and negative
        step("ovf_pos", 0, 0, 1, 16'h7FF0);
        step("ovf_neg", 0, 0, 1, 16'h8000);

        // Clear beats load
        step("clr", 0, 1, 1, 16'h0100);
        step("after_clr", 0, 0, 1, 16'h0100);

        // Fill, hold with toggling input, then load past full
        step("fill2", 0, 0, 1, 16'h0030);
        step("fill3", 0, 0, 1, 16'hFF00);
        step("fill4", 0, 0, 1, 16'h0050);
        for (int i = 0; i < 10; i++)
            step($sformatf("hold%0d", i), 0, 0, 0, (i % 2 == 1) ? 16'h5A5A : 16'hA5A5);
        step("ld5", 0, 0, 1, 16'h0070);

        // Mid-stream reset, then rising-edge-only strobe
        step("pre_rst", 0, 1, 0, 16'h0000);
        step("p1", 0, 0, 1, 16'h0200);
        step("p2", 0, 0, 1, 16'h0300);
        step("mid_rst", 1, 0, 1, 16'h0400);
        chk("mid_rst.fk_zero", int'(fk), 0);
        reset = 1'b0; bandera = 1'b0;
        @(posedge clk);
        bandera = 1'b1; In = 16'h0400;
        #1;
        bandera = 1'b0;
        @(negedge clk);
        #2;
        check_state("posedge_only");
        step("first_after_rst", 0, 0, 1, 16'h0020);

        // Floor shift on a small negative value
        step("neg1", 0, 0, 1, 16'hFFFF);

        chk("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
